cross_sched: RTL and testbench

//   Scheduler for signed 2-D cross products C = (ax-ox)*(by-oy) - (bx-ox)*(ay-oy).
//   - Reuses one shared sub-sub-multiply unit (cross_mac) over two cycles.
//   - Sits between the point-fetch logic and the orientation / inside-test logic.
//   - Valid/ready handshake on both input and output. One result per 3 cycles when streaming.

---
 rtl/cross_pkg.sv | 29 ++
 rtl/cross_mac.sv | 26 ++
 rtl/cross_sched.sv | 127 ++++++++++++
 tb/tb_cross_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cross_pkg.sv
// Shared types and width helpers for the cross-product scheduler.
// Widths are exact: a (COORD_W+1)-bit difference squared never exceeds 2*COORD_W+2 bits.
package cross_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL0 = 2'd1,
    MUL1 = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int diff_w(input int coord_w);
    return coord_w + 1;
  endfunction

  function automatic int prod_w(input int coord_w);
    return 2 * coord_w + 2;
  endfunction

  function automatic int res_w(input int coord_w);
    return 2 * coord_w + 3;
  endfunction

  localparam int COORD_W_DFLT = 16;
  localparam int DIFF_W       = diff_w(COORD_W_DFLT);
  localparam int PROD_W       = prod_w(COORD_W_DFLT);
  localparam int RES_W        = res_w(COORD_W_DFLT);

endpackage

// File: rtl/cross_mac.sv
// Combinational difference-of-differences multiplier: prod = (p0-p1)*(q0-q1).
// Single instance in cross_sched; the scheduler time-shares it across two cycles.
module cross_mac
  import cross_pkg::*;
#(
  parameter int COORD_W = 16
) (
  input  logic signed [COORD_W-1:0]          p0,
  input  logic signed [COORD_W-1:0]          p1,
  input  logic signed [COORD_W-1:0]          q0,
  input  logic signed [COORD_W-1:0]          q1,
  output logic signed [prod_w(COORD_W)-1:0]  prod
);

  localparam int DW = diff_w(COORD_W);
  localparam int PW = prod_w(COORD_W);

  logic signed [DW-1:0] dp;
  logic signed [DW-1:0] dq;

  // One extra bit on each difference keeps the subtraction exact
  assign dp   = DW'(p0) - DW'(p1);
  assign dq   = DW'(q0) - DW'(q1);
  assign prod = PW'(dp) * PW'(dq);

endmodule

// File: rtl/cross_sched.sv
// Two-cycle scheduler for C = (ax-ox)*(by-oy) - (bx-ox)*(ay-oy) over one shared cross_mac.
// Optional macro CROSS_COLINEAR_EN adds registered out_zero/out_neg flags.
module cross_sched
  import cross_pkg::*;
#(
  parameter  int COORD_W = 16,
  localparam int RES_W   = res_w(COORD_W)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] o_x,
  input  logic signed [COORD_W-1:0] o_y,
  input  logic signed [COORD_W-1:0] a_x,
  input  logic signed [COORD_W-1:0] a_y,
  input  logic signed [COORD_W-1:0] b_x,
  input  logic signed [COORD_W-1:0] b_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [RES_W-1:0]   out_data,
`ifdef CROSS_COLINEAR_EN
  output logic                      out_zero,
  output logic                      out_neg,
`endif
  output state_t                    dbg_state
);

  localparam int PW = prod_w(COORD_W);

  state_t state, state_nxt;

  logic signed [COORD_W-1:0] ox_r, oy_r, ax_r, ay_r, bx_r, by_r;
  logic signed [COORD_W-1:0] mac_p0, mac_p1, mac_q0, mac_q1;
  logic signed [PW-1:0]      mac_prod;
  logic signed [PW-1:0]      p0_r;
  logic signed [RES_W-1:0]   res_nxt;
  logic                      accept;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high in IDLE, or in DONE while the consumer is taking the current result,
  // so a new set can be accepted on the same edge the old result retires.
  // out_valid stays high with out_data stable until out_ready is seen.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = MUL0;
      MUL0: state_nxt = MUL1;
      MUL1: state_nxt = DONE;
      DONE: begin
        if (out_ready) state_nxt = in_valid ? MUL0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // First product uses (a_x,o_x,b_y,o_y); MUL1 swaps in the second term's operands
  always_comb begin
    mac_p0 = ax_r;
    mac_p1 = ox_r;
    mac_q0 = by_r;
    mac_q1 = oy_r;
    if (state == MUL1) begin
      mac_p0 = bx_r;
      mac_q0 = ay_r;
    end
  end

  cross_mac #(.COORD_W(COORD_W)) u_mac (
    .p0   (mac_p0),
    .p1   (mac_p1),
    .q0   (mac_q0),
    .q1   (mac_q1),
    .prod (mac_prod)
  );

  assign res_nxt = RES_W'(p0_r) - RES_W'(mac_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox_r      <= '0;
      oy_r      <= '0;
      ax_r      <= '0;
      ay_r      <= '0;
      bx_r      <= '0;
      by_r      <= '0;
      p0_r      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef CROSS_COLINEAR_EN
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        ox_r <= o_x;
        oy_r <= o_y;
        ax_r <= a_x;
        ay_r <= a_y;
        bx_r <= b_x;
        by_r <= b_y;
      end
      if (state == MUL0) p0_r <= mac_prod;
      if (state == MUL1) begin
        out_data  <= res_nxt;
        out_valid <= 1'b1;
`ifdef CROSS_COLINEAR_EN
        out_zero  <= (res_nxt == '0);
        out_neg   <= res_nxt[RES_W-1];
`endif
      end else if ((state == DONE) && out_ready) begin
        // out_data keeps its last value after retirement
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cross_sched.sv
// Self-checking bench for cross_sched: queue-based reference model plus directed checks.
// Build with +define+CROSS_COLINEAR_EN to also check out_zero/out_neg.
module tb_cross_sched;
  import cross_pkg::*;

  localparam int COORD_W = COORD_W_DFLT;

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [COORD_W-1:0] o_x, o_y, a_x, a_y, b_x, b_y;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [RES_W-1:0]   out_data;
`ifdef CROSS_COLINEAR_EN
  logic                      out_zero;
  logic                      out_neg;
`endif
  state_t                    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [RES_W-1:0] exp_q[$];

  cross_sched #(.COORD_W(COORD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o_x       (o_x),
    .o_y       (o_y),
    .a_x       (a_x),
    .a_y       (a_y),
    .b_x       (b_x),
    .b_y       (b_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef CROSS_COLINEAR_EN
    .out_zero  (out_zero),
    .out_neg   (out_neg),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [RES_W-1:0] model(input longint ox, input longint oy,
                                             input longint ax, input longint ay,
                                             input longint bx, input longint by);
    longint r;
    r = (ax - ox) * (by - oy) - (bx - ox) * (ay - oy);
    return r[RES_W-1:0];
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: out_valid with data %0d, no result expected", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL sb_data: got %0d expected %0d", out_data, $signed(exp_q[0]));
          end
`ifdef CROSS_COLINEAR_EN
          n_tests++;
          if (out_zero !== (exp_q[0] == '0) || out_neg !== exp_q[0][RES_W-1]) begin
            n_fail++;
            $display("FAIL sb_flags: got zero=%0b neg=%0b for expected %0d",
                     out_zero, out_neg, $signed(exp_q[0]));
          end
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(o_x, o_y, a_x, a_y, b_x, b_y));
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a set and returns after the accepting edge (+1), reporting edges waited.
  task automatic send(input longint ox, input longint oy, input longint ax,
                      input longint ay, input longint bx, input longint by,
                      output int edges);
    logic taken;
    o_x = COORD_W'(ox); o_y = COORD_W'(oy);
    a_x = COORD_W'(ax); a_y = COORD_W'(ay);
    b_x = COORD_W'(bx); b_y = COORD_W'(by);
    in_valid = 1'b1;
    edges = 0;
    taken = 1'b0;
    while (!taken && edges < 20) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
      edges++;
    end
    in_valid = 1'b0;
    if (!taken) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_out(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) chk("wait_out_timeout", 0, 1);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e;
    int prev_cyc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    o_x = '0; o_y = '0; a_x = '0; a_y = '0; b_x = '0; b_y = '0;
    step(3);
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_out_data", longint'(out_data), 0);
    chk("reset_in_ready", longint'(in_ready), 1);
    chk("reset_state_idle", longint'(dbg_state == IDLE), 1);
    step(1);

    // 1: basic product and two-edge latency
    send(0, 0, 3, 0, 0, 4, e);
    chk("t1_valid_at_T", longint'(out_valid), 0);
    step(1);
    chk("t1_valid_at_T1", longint'(out_valid), 0);
    step(1);
    chk("t1_valid_at_T2", longint'(out_valid), 1);
    chk("t1_data", longint'(out_data), 12);
    step(2);

    // 2: swapped operands and colinear points
    send(0, 0, 0, 4, 3, 0, e);
    wait_out(10);
    chk("t2_swapped", longint'(out_data), -12);
    step(2);
    send(1, 1, 2, 2, 5, 5, e);
    wait_out(10);
    chk("t2_colinear", longint'(out_data), 0);
`ifdef CROSS_COLINEAR_EN
    chk("t2_zero_flag", longint'(out_zero), 1);
    chk("t2_neg_flag", longint'(out_neg), 0);
`endif
    step(2);

    // 3: extreme coordinates, exact result
    send(-32768, 32767, 32767, 32767, -32768, -32768, e);
    wait_out(10);
    chk("t3_extreme", longint'(out_data), -64'sd4294836225);
`ifdef CROSS_COLINEAR_EN
    chk("t3_neg_flag", longint'(out_neg), 1);
`endif
    step(2);

    // 4: back-pressure then same-edge retire/accept
    out_ready = 1'b0;
    send(0, 0, 5, 1, 2, 7, e);
    wait_out(10);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t4_hold_valid", longint'(out_valid), 1);
      chk("t4_hold_data", longint'(out_data), 33);
      chk("t4_hold_in_ready", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    send(0, 0, 1, 0, 0, 1, e);
    chk("t4_same_edge_accept", e, 1);
    chk("t4_retired", longint'(out_valid), 0);
    wait_out(10);
    chk("t4_second", longint'(out_data), 1);
    step(2);

    // 5: stream 8 sets, one accept every 3 cycles
    prev_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      send($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
           $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535), e);
      if (i > 0) chk("t5_throughput", cyc - prev_cyc, 3);
      prev_cyc = cyc;
    end
    wait_out(10);
    step(2);

    // 6: reset during MUL1
    send(0, 0, 3, 0, 0, 4, e);
    step(1);
    chk("t6_in_mul1", longint'(dbg_state == MUL1), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", longint'(out_valid), 0);
    chk("t6_rst_data", longint'(out_data), 0);
    chk("t6_rst_state", longint'(dbg_state == IDLE), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("t6_in_ready_after", longint'(in_ready), 1);
    step(1);
    send(1, 2, 4, 6, -3, 5, e);
    wait_out(10);
    chk("t6_after_reset", longint'(out_data), 25);
    step(2);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
